// File: rtl/dest_reg_pipeline_if.sv
// Destination-register pipeline bus: ID/EX-side inputs and forwarding/WB outputs.
interface dest_reg_pipeline_if #(
  parameter int unsigned REG_BITS = 5
) ();
  logic [REG_BITS-1:0] dest_id;
  logic                reg_write_id;
  logic                mem_read_id;
  logic [REG_BITS-1:0] rs_id;
  logic [REG_BITS-1:0] rt_id;
  logic [REG_BITS-1:0] rs_ex;
  logic [REG_BITS-1:0] rt_ex;
  logic                stall;
  logic                flush;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                load_use;
  logic [REG_BITS-1:0] wb_dest;
  logic                wb_reg_write;

  // Pipeline control side (hazard unit / decode) drives these.
  modport master (
    output dest_id, reg_write_id, mem_read_id, rs_id, rt_id, rs_ex, rt_ex,
           stall, flush,
    input  fwd_a, fwd_b, load_use, wb_dest, wb_reg_write
  );

  // The destination pipeline itself.
  modport slave (
    input  dest_id, reg_write_id, mem_read_id, rs_id, rt_id, rs_ex, rt_ex,
           stall, flush,
    output fwd_a, fwd_b, load_use, wb_dest, wb_reg_write
  );
endinterface

// File: rtl/dest_reg_pipeline.sv
// Carries the ID destination register through EX/MEM/WB and derives
// forwarding selects, load-use stall request and the register-file write port.
module dest_reg_pipeline #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic               clk,
  input  logic               reset,
  dest_reg_pipeline_if.slave bus
);

  localparam logic [REG_BITS-1:0] ZERO = REG_BITS'(ZERO_REG);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic [REG_BITS-1:0] dest;
    logic                reg_write;
    logic                mem_read;
  } stage_t;

  localparam stage_t BUBBLE = '{dest: ZERO, reg_write: 1'b0, mem_read: 1'b0};

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d;

  // Record entering EX: a bubble on stall/flush; writes to the zero register are dropped here.
  always_comb begin
    ex_d = BUBBLE;
    if (!(bus.stall || bus.flush)) begin
      ex_d.dest      = bus.dest_id;
      ex_d.reg_write = bus.reg_write_id && (bus.dest_id != ZERO);
      ex_d.mem_read  = bus.mem_read_id;
    end
  end

  // Stage records advance every cycle; reset clears everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Operand select for one EX source: newest in-flight writer wins, zero register never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src,
                                         input stage_t mem_s,
                                         input stage_t wb_s);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != ZERO) begin
      if (mem_s.reg_write && (mem_s.dest == src)) begin
        sel = FWD_MEM;
      end else if (wb_s.reg_write && (wb_s.dest == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Forwarding selects and load-use detection from the current records.
  always_comb begin
    bus.fwd_a    = fwd_sel(bus.rs_ex, mem_q, wb_q);
    bus.fwd_b    = fwd_sel(bus.rt_ex, mem_q, wb_q);
    bus.load_use = ex_q.mem_read && ex_q.reg_write && (ex_q.dest != ZERO) &&
                   ((ex_q.dest == bus.rs_id) || (ex_q.dest == bus.rt_id));
  end

  // Register-file write port comes straight from the WB record.
  assign bus.wb_dest      = wb_q.dest;
  assign bus.wb_reg_write = wb_q.reg_write;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Scoreboard bench for dest_reg_pipeline: an instruction-history model predicts
// every cycle's outputs; a negedge monitor compares the DUT against them.
module tb_dest_reg_pipeline;

  logic clk;
  logic reset;

  dest_reg_pipeline_if #(.REG_BITS(5)) bus ();

  dest_reg_pipeline #(.REG_BITS(5), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An instruction as the model remembers it once it has left ID.
  typedef struct packed {
    logic [4:0] dest;
    logic       writes;
    logic       load;
  } instr_t;

  typedef struct {
    string      tag;
    int         cyc;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       load_use;
    logic [4:0] wb_dest;
    logic       wb_reg_write;
  } exp_t;

  localparam instr_t NOP = '{dest: 5'd31, writes: 1'b0, load: 1'b0};

  // history[k] = instruction that left ID k+1 cycles ago (age 0 is in EX).
  instr_t history[$];
  exp_t   exp_q[$];
  int     vectors;
  int     miscompares;
  int     cyc;
  string  cur_tag;

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    // Newest older writer (age 1 = MEM, age 2 = WB) supplies the operand.
    if (src == 5'd31) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (history[age].writes && history[age].dest == src) return 2'(age);
    end
    return 2'b00;
  endfunction

  function automatic logic model_lu(input logic [4:0] rsid, input logic [4:0] rtid);
    instr_t e;
    e = history[0];
    return e.load && e.writes && e.dest != 5'd31 && (e.dest == rsid || e.dest == rtid);
  endfunction

  // Drive one cycle of inputs, predict the outputs seen during it, then clock.
  task automatic cycle(input logic rst, input logic [4:0] dest, input logic rw,
                       input logic mr, input logic [4:0] rsid, input logic [4:0] rtid,
                       input logic [4:0] rsex, input logic [4:0] rtex,
                       input logic st, input logic fl);
    exp_t   e;
    instr_t n;
    reset            = rst;
    bus.dest_id      = dest;
    bus.reg_write_id = rw;
    bus.mem_read_id  = mr;
    bus.rs_id        = rsid;
    bus.rt_id        = rtid;
    bus.rs_ex        = rsex;
    bus.rt_ex        = rtex;
    bus.stall        = st;
    bus.flush        = fl;
    e.tag          = cur_tag;
    e.cyc          = cyc;
    e.fwd_a        = model_fwd(rsex);
    e.fwd_b        = model_fwd(rtex);
    e.load_use     = model_lu(rsid, rtid);
    e.wb_dest      = history[2].dest;
    e.wb_reg_write = history[2].writes;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      history = '{NOP, NOP, NOP};
    end else begin
      if (st || fl) n = NOP;
      else n = '{dest: dest, writes: rw && dest != 5'd31, load: mr};
      history.push_front(n);
      void'(history.pop_back());
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] rnd_reg();
    int unsigned r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  // Monitor: every output cycle pops one prediction and compares all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.fwd_a !== e.fwd_a) begin
        miscompares++;
        $display("FAIL %s fwd_a cyc=%0d got=%b exp=%b", e.tag, e.cyc, bus.fwd_a, e.fwd_a);
      end
      if (bus.fwd_b !== e.fwd_b) begin
        miscompares++;
        $display("FAIL %s fwd_b cyc=%0d got=%b exp=%b", e.tag, e.cyc, bus.fwd_b, e.fwd_b);
      end
      if (bus.load_use !== e.load_use) begin
        miscompares++;
        $display("FAIL %s load_use cyc=%0d got=%b exp=%b", e.tag, e.cyc, bus.load_use, e.load_use);
      end
      if (bus.wb_dest !== e.wb_dest) begin
        miscompares++;
        $display("FAIL %s wb_dest cyc=%0d got=%0d exp=%0d", e.tag, e.cyc, bus.wb_dest, e.wb_dest);
      end
      if (bus.wb_reg_write !== e.wb_reg_write) begin
        miscompares++;
        $display("FAIL %s wb_reg_write cyc=%0d got=%b exp=%b", e.tag, e.cyc, bus.wb_reg_write, e.wb_reg_write);
      end
    end
  end

  initial begin
    logic [4:0] d, rsid, rtid;
    logic       rw, mr, st, fl, rst;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    cur_tag     = "reset";
    history     = '{NOP, NOP, NOP};
    reset = 1'b1;
    bus.dest_id = 5'd0; bus.reg_write_id = 1'b0; bus.mem_read_id = 1'b0;
    bus.rs_id = 5'd0; bus.rt_id = 5'd0; bus.rs_ex = 5'd0; bus.rt_ex = 5'd0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    cur_tag = "single";
    cycle(1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(5);

    cur_tag = "mem_over_wb";
    cycle(1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0);

    cur_tag = "zero_reg";
    cycle(1'b0, 5'd31, 1'b1, 1'b0, 5'd0, 5'd0, 5'd31, 5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0);

    cur_tag = "load_use";
    cycle(1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd8, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd8, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(4);

    cur_tag = "flush_stall";
    cycle(1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    idle(4);

    cur_tag = "reset_mid";
    cycle(1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 5'd6, 1'b1, 1'b0, 5'd1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd1, 5'd2, 1'b0, 1'b0);

    cur_tag = "random";
    for (int i = 0; i < 2000; i++) begin
      d    = rnd_reg();
      rw   = ($urandom_range(0, 3) != 0);
      mr   = ($urandom_range(0, 2) == 0);
      rsid = rnd_reg();
      rtid = rnd_reg();
      st   = model_lu(rsid, rtid) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cycle(rst, d, rw, mr, rsid, rtid, rnd_reg(), rnd_reg(), st, fl);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dest_reg_pipeline.md
Name: dest_reg_pipeline

Overview:
- Consumes the 5-bit destination-register number selected in the ID stage and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Carries it together with its reg_write and mem_read control bits.
- From the in-flight destinations it produces the EX-stage forwarding selects, the load-use stall request and the register-file write address/enable for WB.
- Register 31 is the hard-wired zero register (XZR). It is never a forwarding or hazard source and is never written.

Parameters:
- REG_BITS, 5, width of a register number.
- ZERO_REG, 31, index of the zero register; excluded from all matching and write enables.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- dest_id  input  REG_BITS  destination register selected in ID (Rd or Rt).
- reg_write_id  input  1  the ID instruction writes the register file.
- mem_read_id  input  1  the ID instruction is a load.
- rs_id, rt_id  input  REG_BITS each  source registers of the instruction currently in ID.
- rs_ex, rt_ex  input  REG_BITS each  source registers of the instruction currently in EX.
- stall  input  1  hold ID; insert a bubble into EX.
- flush  input  1  squash the ID instruction; insert a bubble into EX.
- fwd_a, fwd_b  output  2 each  ALU operand select: 00 register file, 01 from MEM stage, 10 from WB stage.
- load_use  output  1  request to stall ID.
- wb_dest  output  REG_BITS  register-file write address.
- wb_reg_write  output  1  register-file write enable.

Behaviour:
- State: three stage records (EX, MEM, WB). Each record holds dest, reg_write and mem_read.
- Reset (posedge with reset=1): every record becomes dest=31, reg_write=0, mem_read=0. Resulting outputs:
  - wb_dest=31, wb_reg_write=0
  - fwd_a=fwd_b=00, load_use=0
- Reset mid-operation discards all in-flight records. Reset has priority over stall and flush.
- Normal advance (posedge, no reset): WB<=MEM, MEM<=EX, EX<=ID inputs.
- Latency: dest_id presented at cycle N appears on wb_dest at cycle N+3.
- stall=1 or flush=1: EX loads a bubble (dest=31, reg_write=0, mem_read=0). MEM and WB still advance, so older instructions drain.
- stall and flush together: EX loads a bubble; same effect as either alone.
- Write suppression: a record whose dest=31 has its effective reg_write forced to 0 when captured into EX. Therefore wb_reg_write=1 never occurs with wb_dest=31.
- Forwarding is combinational from the current MEM/WB records and rs_ex/rt_ex. fwd_a for rs_ex:
  - 01 if MEM.reg_write && MEM.dest==rs_ex && rs_ex!=31
  - else 10 if WB.reg_write && WB.dest==rs_ex && rs_ex!=31
  - else 00
  - MEM has priority over WB (newest value wins).
  - fwd_b is identical, using rt_ex.
- load_use (combinational) = EX.mem_read && EX.reg_write && EX.dest!=31 && (EX.dest==rs_id || EX.dest==rt_id).
  - The block does not self-stall. The hazard unit feeds load_use back on stall; the next posedge then inserts the bubble, so load_use deasserts one cycle later.
- wb_dest and wb_reg_write are driven directly from the WB record (registered outputs, no combinational path from inputs).

Test Plan:
- Reset, then a single instruction: reset 2 cycles; dest_id=5, reg_write_id=1 at cycle 0 -> wb_dest=5 and wb_reg_write=1 exactly at cycle 3, and 0 at cycles 0-2 and 4 (bubbles follow).
- MEM-over-WB priority: consecutive writes to X3 (value A then B), next instruction has rs_ex=3 -> fwd_a=01. One cycle later, with no newer writer, rs_ex=3 -> fwd_a=10.
- Zero register: write to X31 with reg_write_id=1, followed by rs_ex=31, rt_ex=31 -> fwd_a=fwd_b=00 and wb_reg_write stays 0 when the record reaches WB.
- Load-use: load with dest_id=7, mem_read_id=1 enters EX while rt_id=7 -> load_use=1. Drive stall=1 that cycle -> next cycle EX is a bubble, load_use=0, and the load reaches WB on schedule.
- Flush while stalled: stall=1 and flush=1 with dest_id=9 -> X9 never appears on wb_dest, and older MEM/WB records still retire in order.
- Reset mid-flight: three writers (X1, X2, X4) in EX/MEM/WB, assert reset one cycle -> next cycle wb_reg_write=0, wb_dest=31, fwd_a=fwd_b=00, and no later write of X1/X2/X4.
